// File: rtl/pwm_decode.sv
// -----------------------------------------------------------------------------
// pwm_decode
//   Measures the low and high phase lengths, in clk cycles, of an asynchronous
//   PWM waveform. The input is synchronised, edges are detected, and a small
//   FSM counts each phase.
//   - A period is reported when the rising edge that closes it arrives.
//   - If a level is held too long to be measured, a timeout reports an
//     all-ones count for that level and raises stuck.
//
// Parameters
//   WIDTH    bit width of the phase counter and of the reported counts
//
// Ports
//   clk      single clock, all state updates on its rising edge
//   r        synchronous active-high reset
//   in       PWM waveform, asynchronous to clk
//   off_cyc  low-phase length of the last complete period
//   on_cyc   high-phase length of the last complete period
//   valid    one-cycle pulse when off_cyc/on_cyc are updated
//   stuck    high while the input has held one level past the counter range
// -----------------------------------------------------------------------------
module pwm_decode #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             in,
    output logic [WIDTH-1:0] off_cyc,
    output logic [WIDTH-1:0] on_cyc,
    output logic             valid,
    output logic             stuck
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic             sync1_q, sync1_d;
    logic             in_s_q, in_s_d;
    logic             in_d_q, in_d_d;
    logic [1:0]       warm_q, warm_d;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] on_tmp_q, on_tmp_d;
    logic [WIDTH-1:0] off_cyc_q, off_cyc_d;
    logic [WIDTH-1:0] on_cyc_q, on_cyc_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;

    logic             warm_done;
    logic             rise;
    logic             fall;
    logic             timeout;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // The synchroniser flops restart at zero, so the first few cycles after
    // reset can show an edge that never happened on the pin; those are masked.
    assign warm_done = (warm_q == 2'd3);
    assign rise      = warm_done &  in_s_q & ~in_d_q;
    assign fall      = warm_done & ~in_s_q &  in_d_q;
    assign timeout   = (cnt_q == CNT_MAX) & ~rise & ~fall & ~stuck_q;

    always_comb begin
        sync1_d   = in;
        in_s_d    = sync1_q;
        in_d_d    = in_s_q;
        warm_d    = warm_done ? warm_q : warm_q + 2'd1;
        state_d   = state_q;
        cnt_d     = sat_inc(cnt_q);
        on_tmp_d  = on_tmp_q;
        off_cyc_d = off_cyc_q;
        on_cyc_d  = on_cyc_q;
        valid_d   = 1'b0;
        stuck_d   = stuck_q;

        // Any real edge ends a stuck condition.
        if (rise || fall) begin
            stuck_d = 1'b0;
        end

        if (timeout) begin
            // Report the level that overflowed as all-ones, the other as zero.
            stuck_d   = 1'b1;
            valid_d   = 1'b1;
            state_d   = IDLE;
            cnt_d     = CNT_MAX;
            off_cyc_d = in_s_q ? '0 : CNT_MAX;
            on_cyc_d  = in_s_q ? CNT_MAX : '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A fall here still restarts the count so that a
                    // saturated count from a stuck period does not
                    // immediately trigger a second timeout.
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ONE;
                    end else if (fall) begin
                        cnt_d   = CNT_ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d  = LOW;
                        on_tmp_d = cnt_q;
                        cnt_d    = CNT_ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_d   = HIGH;
                        off_cyc_d = cnt_q;
                        on_cyc_d  = on_tmp_q;
                        valid_d   = 1'b1;
                        cnt_d     = CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            sync1_q   <= 1'b0;
            in_s_q    <= 1'b0;
            in_d_q    <= 1'b0;
            warm_q    <= 2'd0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            on_tmp_q  <= '0;
            off_cyc_q <= '0;
            on_cyc_q  <= '0;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            in_s_q    <= in_s_d;
            in_d_q    <= in_d_d;
            warm_q    <= warm_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            on_tmp_q  <= on_tmp_d;
            off_cyc_q <= off_cyc_d;
            on_cyc_q  <= on_cyc_d;
            valid_q   <= valid_d;
            stuck_q   <= stuck_d;
        end
    end

    assign off_cyc = off_cyc_q;
    assign on_cyc  = on_cyc_q;
    assign valid   = valid_q;
    assign stuck   = stuck_q;

endmodule

// File: tb/tb_pwm_decode.sv
// -----------------------------------------------------------------------------
// tb_pwm_decode
//   Scoreboard bench for pwm_decode. Two instances: WIDTH=4 (dut4) and
//   WIDTH=8 (dut8). Stimulus drives one input level per clock cycle, like a
//   PWM generator on the same clock, and pushes the expected (off, on, cycle)
//   of every report into a per-instance queue. Monitors pop and compare each
//   time valid is seen. A raw level change made just after edge c is expected
//   to produce valid in the cycle after edge c+3.
// -----------------------------------------------------------------------------
module tb_pwm_decode;

    typedef struct {
        int off_v;
        int on_v;
        int cyc_v;
    } exp_t;

    logic       clk = 1'b0;
    logic       r4, r8, in4, in8;
    logic [3:0] off4, on4;
    logic [7:0] off8, on8;
    logic       valid4, valid8, stuck4, stuck8;

    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   prev4  = 1'b0;
    bit   prev8  = 1'b0;
    exp_t q4[$];
    exp_t q8[$];

    pwm_decode #(.WIDTH(4)) dut4 (
        .clk(clk), .r(r4), .in(in4),
        .off_cyc(off4), .on_cyc(on4), .valid(valid4), .stuck(stuck4)
    );

    pwm_decode #(.WIDTH(8)) dut8 (
        .clk(clk), .r(r8), .in(in8),
        .off_cyc(off8), .on_cyc(on8), .valid(valid8), .stuck(stuck8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic pop_check(input bit sel, input int offv, input int onv);
        exp_t e;
        int   sz;
        sz = sel ? q8.size() : q4.size();
        if (sz == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_valid_w%0d: off=%0d on=%0d at cycle %0d, none expected",
                     sel ? 8 : 4, offv, onv, cyc);
        end else begin
            if (sel) e = q8.pop_front();
            else     e = q4.pop_front();
            check(sel ? "off8" : "off4", offv, e.off_v);
            check(sel ? "on8" : "on4", onv, e.on_v);
            check(sel ? "valid_cycle8" : "valid_cycle4", cyc, e.cyc_v);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        if (valid4) begin
            check("double_valid4", int'(prev4), 0);
            pop_check(1'b0, int'(off4), int'(on4));
        end
        prev4 = valid4;
    end

    always @(negedge clk) begin
        if (valid8) begin
            check("double_valid8", int'(prev8), 0);
            pop_check(1'b1, int'(off8), int'(on8));
        end
        prev8 = valid8;
    end

    task automatic push(input bit sel, input int offv, input int onv, input int at);
        exp_t e;
        e.off_v = offv;
        e.on_v  = onv;
        e.cyc_v = at;
        if (sel) q8.push_back(e);
        else     q4.push_back(e);
    endtask

    task automatic step(input bit sel, input logic v);
        @(posedge clk);
        #1;
        if (sel) in8 = v;
        else     in4 = v;
    endtask

    // Reset with the input at level lvl, then check every output is zero.
    task automatic do_reset(input bit sel, input logic lvl);
        @(posedge clk);
        #1;
        if (sel) begin r8 = 1'b1; in8 = lvl; end
        else     begin r4 = 1'b1; in4 = lvl; end
        @(posedge clk);
        #1;
        if (sel) begin
            r8 = 1'b0;
            check("rst_off8", int'(off8), 0);
            check("rst_on8", int'(on8), 0);
            check("rst_valid8", int'(valid8), 0);
            check("rst_stuck8", int'(stuck8), 0);
        end else begin
            r4 = 1'b0;
            check("rst_off4", int'(off4), 0);
            check("rst_on4", int'(on4), 0);
            check("rst_valid4", int'(valid4), 0);
            check("rst_stuck4", int'(stuck4), 0);
        end
    endtask

    // nper+1 rising edges; each after the first closes a period (off_n, on_n).
    // Ends high with three extra cycles so the last report is observed.
    task automatic run_pwm(input bit sel, input int off_n, input int on_n, input int nper);
        for (int p = 0; p <= nper; p++) begin
            step(sel, 1'b1);
            if (p > 0) push(sel, off_n, on_n, cyc + 3);
            for (int i = 1; i < on_n; i++) step(sel, 1'b1);
            if (p < nper) begin
                for (int i = 0; i < off_n; i++) step(sel, 1'b0);
            end
        end
        repeat (3) step(sel, 1'b1);
    endtask

    initial begin
        int c;
        r4  = 1'b1;
        r8  = 1'b1;
        in4 = 1'b0;
        in8 = 1'b0;
        repeat (3) @(posedge clk);

        // WIDTH=8: high through reset, then off=10/on=7.
        do_reset(1'b1, 1'b1);
        repeat (6) step(1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0);
        run_pwm(1'b1, 10, 7, 2);
        #1 r8 = 1'b1;

        // WIDTH=4: off=3/on=5, reports every 8 cycles.
        do_reset(1'b0, 1'b0);
        run_pwm(1'b0, 3, 5, 4);

        // WIDTH=4: held high from reset -> one timeout report (0, 15).
        do_reset(1'b0, 1'b1);
        push(1'b0, 0, 15, cyc + 16);
        repeat (20) step(1'b0, 1'b1);
        check("stuck_high", int'(stuck4), 1);
        step(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("stuck_before_fall_seen", int'(stuck4), 1);
        @(posedge clk);
        #1;
        check("stuck_cleared_by_fall", int'(stuck4), 0);
        check("off_hold_after_timeout", int'(off4), 0);
        check("on_hold_after_timeout", int'(on4), 15);

        // WIDTH=4: one period, then held low -> timeout report (15, 0).
        do_reset(1'b0, 1'b0);
        run_pwm(1'b0, 3, 5, 1);
        step(1'b0, 1'b0);
        push(1'b0, 15, 0, cyc + 18);
        repeat (19) step(1'b0, 1'b0);
        check("stuck_low", int'(stuck4), 1);
        check("off_timeout_low", int'(off4), 15);
        check("on_timeout_low", int'(on4), 0);
        run_pwm(1'b0, 3, 5, 1);
        check("stuck_cleared_by_rise", int'(stuck4), 0);

        // WIDTH=4: 2/2 waveform, reset pulsed while the FSM is in LOW.
        do_reset(1'b0, 1'b0);
        run_pwm(1'b0, 2, 2, 2);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        @(posedge clk);
        #1;
        in4 = 1'b1;
        r4  = 1'b1;
        @(posedge clk);
        #1;
        check("midlow_rst_off", int'(off4), 0);
        check("midlow_rst_on", int'(on4), 0);
        check("midlow_rst_valid", int'(valid4), 0);
        check("midlow_rst_stuck", int'(stuck4), 0);
        r4  = 1'b0;
        in4 = 1'b0;
        step(1'b0, 1'b0);
        run_pwm(1'b0, 2, 2, 1);

        // WIDTH=4: minimum waveform off=1/on=1.
        do_reset(1'b0, 1'b0);
        run_pwm(1'b0, 1, 1, 4);

        repeat (6) @(posedge clk);
        #1;
        c = q4.size();
        check("pending_reports_w4", c, 0);
        c = q8.size();
        check("pending_reports_w8", c, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
